// File: rtl/sram_like_arbiter_if.sv
// SRAM-like bus bundle: request/payload from the master, handshakes and read data back.
interface sram_like_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              addr_ok;
  logic              data_ok;

  modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
  modport slave  (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like slave port between the instruction and data masters,
// one outstanding transaction at a time.
//
// state | meaning
// IDLE  | no owner; sel is picked combinationally and presented to the slave
// REQ   | owner locked, holding its request until the slave accepts the address
// RESP  | address accepted, waiting for the slave's data_ok
module sram_like_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RR_EN  = 0
) (
  input  logic                       clk,
  input  logic                       resetn,
  sram_like_arbiter_if.slave         inst,
  sram_like_arbiter_if.slave         data,
  sram_like_arbiter_if.master        mem
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  localparam logic M_INST = 1'b0;
  localparam logic M_DATA = 1'b1;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              sel;
  logic              cur;
  logic              cur_req;
  logic              grant;
  logic              resp_done;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;

  always_comb begin
    sel = M_INST;
    if (inst.req && data.req) sel = (RR_EN != 0) ? ~last_q : M_DATA;
    else if (data.req)        sel = M_DATA;
    // once locked, only the owner may drive the slave
    cur       = (state_q == IDLE) ? sel : owner_q;
    cur_req   = (state_q != RESP) && ((cur == M_DATA) ? data.req : inst.req);
    cur_addr  = (cur == M_DATA) ? data.addr  : inst.addr;
    cur_wdata = (cur == M_DATA) ? data.wdata : inst.wdata;
    grant     = cur_req && mem.addr_ok;
    resp_done = (state_q == RESP) && mem.data_ok;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= M_INST;
      last_q  <= M_INST;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (cur_req) begin
          owner_d = sel;
          if (grant) begin
            last_d  = sel;
            state_d = RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (!cur_req) begin
          state_d = IDLE;
        end else if (grant) begin
          last_d  = owner_q;
          state_d = RESP;
        end
      end
      RESP: begin
        if (mem.data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // handshakes are gated by resetn so they drop the instant reset asserts
  always_comb begin
    mem.req      = resetn && cur_req;
    mem.wr       = (cur == M_DATA) ? data.wr   : inst.wr;
    mem.size     = (cur == M_DATA) ? data.size : inst.size;
    mem.addr     = cur_addr;
    mem.wdata    = cur_wdata;
    inst.addr_ok = resetn && grant && (cur == M_INST);
    data.addr_ok = resetn && grant && (cur == M_DATA);
    inst.data_ok = resetn && resp_done && (owner_q == M_INST);
    data.data_ok = resetn && resp_done && (owner_q == M_DATA);
    inst.rdata   = mem.rdata;
    data.rdata   = mem.rdata;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one SRAM-like memory port between the fetch stage's instruction master (inst_*) and the memory stage's data master (data_*).
- Sits between the CPU core and the single AXI-bridge/SRAM-like slave.
- Serialises transactions: one outstanding transaction at a time.
- Steers addr_ok/data_ok/rdata back to the master that owns the transaction.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, read/write data width.
- RR_EN, 0, arbitration mode: 0 = fixed priority (data over inst); 1 = round-robin between masters on simultaneous requests.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- resetn  in  1  reset, asynchronous, active-low.
- inst_req / inst_wr  in  1 / 1  instruction master request / write flag (always 0 from fetch).
- inst_size  in  2  access size.
- inst_addr / inst_wdata  in  ADDR_W / DATA_W  address / write data.
- inst_rdata  out  DATA_W  read data.
- inst_addr_ok / inst_data_ok  out  1 / 1  handshakes to instruction master.
- data_req / data_wr / data_size / data_addr / data_wdata  in  1/1/2/ADDR_W/DATA_W  data master request.
- data_rdata / data_addr_ok / data_data_ok  out  DATA_W/1/1  data master responses.
- mem_req / mem_wr / mem_size / mem_addr / mem_wdata  out  1/1/2/ADDR_W/DATA_W  to slave.
- mem_rdata / mem_addr_ok / mem_data_ok  in  DATA_W/1/1  from slave.

Behaviour:
- Reset:
  - Clock and reset are one clock `clk` and `resetn`, asynchronous, active-low.
  - While resetn=0: state=IDLE, owner=INST, last_grant=INST.
  - mem_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok are all 0.
  - Reset mid-transaction abandons it; no data_ok is delivered after release.
- States: IDLE, REQ (owner locked, waiting for slave addr_ok), RESP (address accepted, waiting for data_ok).
- IDLE:
  - sel is chosen combinationally.
    - Only one master requesting: sel = that master.
    - Both requesting, RR_EN=0: sel = DATA.
    - Both requesting, RR_EN=1: sel = the master not equal to last_grant.
  - mem_* = sel master's signals; mem_req = inst_req|data_req.
  - Same-cycle mem_addr_ok: pulse addr_ok to sel; owner<=sel; last_grant<=sel; next state RESP.
  - No mem_addr_ok while mem_req=1: owner<=sel; next state REQ.
  - No request: stay in IDLE.
- REQ:
  - mem_* is driven from owner only, with mem_req=1; owner does not change even if the other master asserts req.
  - On mem_addr_ok: owner's addr_ok=1; last_grant<=owner; go to RESP.
  - Owner must hold req and payload stable until addr_ok (SRAM-like rule). If owner drops req, mem_req drops and the block returns to IDLE.
- RESP:
  - mem_req=0; no addr_ok to either master.
  - On mem_data_ok: owner's data_ok=1 for that cycle; next state IDLE. A new grant starts the following cycle, so back-to-back transactions have a 1-cycle bubble.
- Response routing:
  - inst_rdata = data_rdata = mem_rdata (broadcast).
  - data_ok goes only to the owner; the non-owner's addr_ok/data_ok are always 0.
- Stray inputs:
  - mem_data_ok in IDLE/REQ is ignored.
  - mem_addr_ok while mem_req=0 is ignored.
- Write transactions (data_wr=1) follow the same flow; slave data_ok is the write acknowledge.
- Invariant: at most one of inst_addr_ok/data_addr_ok, and at most one of inst_data_ok/data_data_ok, high in any cycle.
- Latency:
  - Zero-wait slave: addr_ok in the grant cycle; data_ok N cycles later, as the slave returns it.
  - Minimum issue interval per transaction: 2 cycles.

Test Plan:
- Single fetch:
  - Stimulus: inst_req=1, inst_addr=0xbfc00000; slave gives addr_ok same cycle and data_ok next cycle with rdata=0x3c080001.
  - Required: inst_addr_ok in cycle 0; inst_data_ok and inst_rdata=0x3c080001 in cycle 1; data_* handshakes stay 0.
- Simultaneous requests, RR_EN=0:
  - Stimulus: inst_req and data_req (data_addr=0x80001000, data_wr=1, wdata=0xdeadbeef) high together.
  - Required: mem_addr=0x80001000, mem_wr=1 first; inst granted only after data_data_ok plus 1 cycle.
- Round-robin, RR_EN=1:
  - Stimulus: both masters request continuously for 4 transactions.
  - Required: grant order DATA, INST, DATA, INST (last_grant=INST at reset).
- Lock in REQ:
  - Stimulus: inst requests; slave withholds addr_ok for 3 cycles; data_req rises in cycle 1.
  - Required: mem_addr stays the inst address for all 3 cycles; data is served only after inst data_ok.
- Async reset mid-RESP:
  - Stimulus: resetn driven low between clock edges while in RESP.
  - Required: all handshake outputs 0 immediately, with no clock edge; after release, mem_data_ok=1 produces no data_ok, and a new inst_req is granted from IDLE.
- Stray slave data_ok:
  - Stimulus: mem_data_ok=1 in IDLE.
  - Required: no data_ok on either master; state stays IDLE.
